// File: rtl/rsa_pkg.sv
// rsa_pkg
// Shared definitions for the RSA modular-exponentiation sequencer:
//   - state_e : sequencer state encoding
//   - SEL_C / SEL_R : multiplier operand-B select codes
//   - W_DEF   : default key/exponent width
package rsa_pkg;

    localparam int W_DEF = 256;

    localparam logic SEL_C = 1'b0;
    localparam logic SEL_R = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        CHK,
        MUL,
        WMUL,
        SQR_CHK,
        SQR,
        WSQR,
        DONE
    } state_e;

endpackage

// File: rtl/rsa_bit_cnt.sv
// rsa_bit_cnt
// Exponent bit-index counter. Cleared at the start of a run and stepped
// after each squaring completes. It holds at W-1 instead of wrapping.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   clr_i  : clear index to 0 (has priority over inc_i)
//   inc_i  : advance index by one
//   idx_o  : current bit index
//   last_o : index is W-1 (most significant exponent bit)
module rsa_bit_cnt #(
    parameter int W  = 256,
    parameter int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] idx_o,
    output logic          last_o
);

    logic [CW-1:0] idx_q;
    logic [CW-1:0] idx_d;

    assign last_o = (idx_q == CW'(W - 1));
    assign idx_o  = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i && !last_o) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl
// Sequencer for m = c^d mod N using right-to-left square-and-multiply on a
// shared external modular multiplier, one operation at a time.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   start      : host pulse, accepted only in IDLE
//   ready      : result available (high from completion to next start)
//   busy       : run in progress
//   exp_idx    : bit index into the d register; exp_bit is d[exp_idx]
//   init_o     : load R<-1, C<-c
//   mm_start   : launch a multiply; mm_sel_b held until mm_done
//   mm_sel_b   : 0 = R*C into R, 1 = C*C into C
//   mm_done    : multiplier result valid
//   wr_r/wr_c  : product write strobes (mm_done gated by wait state)
//   wr_out     : a0<-R in the DONE cycle
//
// state   | meaning
// IDLE    | waiting for start
// INIT    | load R and C, index cleared
// CHK     | test exponent bit d[exp_idx]
// MUL     | launch R*C
// WMUL    | wait for multiply, write R
// SQR_CHK | last bit reached? then finish, final squaring skipped
// SQR     | launch C*C
// WSQR    | wait for squaring, write C, advance index
// DONE    | write result to a0, raise ready
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          ready,
    output logic [CW-1:0] exp_idx,
    input  logic          exp_bit,
    output logic          init_o,
    output logic          mm_start,
    output logic          mm_sel_b,
    input  logic          mm_done,
    output logic          wr_r,
    output logic          wr_c,
    output logic          wr_out,
    output logic          busy
);

    state_e state_q;
    logic   ready_q;
    logic   busy_q;
    logic   init_q;
    logic   mm_start_q;
    logic   sel_q;
    logic   wr_out_q;
    logic   last;
    logic   cnt_clr;
    logic   cnt_inc;

    // Index is cleared as start is accepted so it already reads 0 in INIT.
    assign cnt_clr = (state_q == IDLE) && start;
    assign cnt_inc = (state_q == WSQR) && mm_done;

    rsa_bit_cnt #(
        .W  (W),
        .CW (CW)
    ) u_bit_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .idx_o  (exp_idx),
        .last_o (last)
    );

    // A done pulse outside the wait states never produces a write.
    assign wr_r = (state_q == WMUL) && mm_done;
    assign wr_c = (state_q == WSQR) && mm_done;

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign init_o   = init_q;
    assign mm_start = mm_start_q;
    assign mm_sel_b = sel_q;
    assign wr_out   = wr_out_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            init_q     <= 1'b0;
            mm_start_q <= 1'b0;
            sel_q      <= 1'b0;
            wr_out_q   <= 1'b0;
        end else begin
            init_q     <= 1'b0;
            mm_start_q <= 1'b0;
            wr_out_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= INIT;
                        init_q  <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                INIT: state_q <= CHK;
                CHK: begin
                    if (exp_bit) begin
                        state_q    <= MUL;
                        mm_start_q <= 1'b1;
                        sel_q      <= SEL_C;
                    end else begin
                        state_q <= SQR_CHK;
                    end
                end
                MUL: state_q <= WMUL;
                WMUL: begin
                    if (mm_done) begin
                        state_q <= SQR_CHK;
                    end
                end
                SQR_CHK: begin
                    if (last) begin
                        state_q  <= DONE;
                        wr_out_q <= 1'b1;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        state_q    <= SQR;
                        mm_start_q <= 1'b1;
                        sel_q      <= SEL_R;
                    end
                end
                SQR: state_q <= WSQR;
                WSQR: begin
                    if (mm_done) begin
                        state_q <= CHK;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb_rsa_exp_ctrl
// Bench for rsa_exp_ctrl with W=8, N=251: behavioural register file
// (R, C, a0, d) and modular multiplier with configurable latency.
module tb_rsa_exp_ctrl;

    localparam int W      = 8;
    localparam int CW     = 3;
    localparam int N      = 251;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          ready;
    logic [CW-1:0] exp_idx;
    logic          exp_bit;
    logic          init_o;
    logic          mm_start;
    logic          mm_sel_b;
    logic          mm_done = 1'b0;
    logic          wr_r;
    logic          wr_c;
    logic          wr_out;
    logic          busy;

    logic [7:0] d_reg = 8'h00;
    logic [7:0] c_val = 8'h00;
    logic [7:0] r_reg;
    logic [7:0] c_reg;
    logic [7:0] a0;

    int lat_min = 1;
    int lat_max = 1;

    // monitor counters, each written by one process only
    int n_wr_r = 0, n_wr_c = 0, n_mul = 0, n_sqr = 0, n_done = 0;
    int sel_err = 0, ready_rises = 0, wraps = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign exp_bit = d_reg[exp_idx];

    rsa_exp_ctrl #(.W(W), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ready    (ready),
        .exp_idx  (exp_idx),
        .exp_bit  (exp_bit),
        .init_o   (init_o),
        .mm_start (mm_start),
        .mm_sel_b (mm_sel_b),
        .mm_done  (mm_done),
        .wr_r     (wr_r),
        .wr_c     (wr_c),
        .wr_out   (wr_out),
        .busy     (busy)
    );

    // register file writes
    logic [15:0] prod;
    always @(posedge clk) begin
        if (init_o) begin
            r_reg <= 8'd1;
            c_reg <= c_val;
        end
        if (wr_r) begin
            r_reg  <= prod[7:0];
            n_wr_r <= n_wr_r + 1;
        end
        if (wr_c) begin
            c_reg  <= prod[7:0];
            n_wr_c <= n_wr_c + 1;
        end
        if (wr_out) a0 <= r_reg;
    end

    // multiplier: mm_start seen in cycle k -> mm_done high in cycle k+L
    int   pend = 0;
    logic pend_sel = 1'b0;
    logic ready_prev = 1'b0;
    logic [CW-1:0] idx_prev = '0;
    always @(negedge clk) begin
        mm_done = 1'b0;
        if (pend > 0) begin
            if (mm_sel_b !== pend_sel) sel_err++;
            pend--;
            if (pend == 0) begin
                mm_done = 1'b1;
                n_done++;
            end
        end
        if (mm_start) begin
            pend_sel = mm_sel_b;
            if (mm_sel_b) begin
                prod = 16'((int'(c_reg) * int'(c_reg)) % N);
                n_sqr++;
            end else begin
                prod = 16'((int'(r_reg) * int'(c_reg)) % N);
                n_mul++;
            end
            pend = int'($urandom_range(lat_max, lat_min));
        end
        if (ready && !ready_prev) ready_rises++;
        ready_prev = ready;
        if (busy && !init_o && exp_idx == 3'd0 && idx_prev == 3'(W - 1)) wraps++;
        idx_prev = exp_idx;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] modexp_ref(input logic [7:0] c, input logic [7:0] d);
        int acc;
        acc = 1;
        for (int i = 0; i < int'(d); i++) acc = (acc * int'(c)) % N;
        return acc[7:0];
    endfunction

    // One full exponentiation. exp_cyc = 0 skips the cycle-count comparison.
    task automatic run(input string tag, input logic [7:0] c, input logic [7:0] d,
                       input int lmin, input int lmax, input logic [7:0] exp_a0,
                       input int exp_cyc, input int exp_mul, input bit inject);
        int b_wr_r, b_wr_c, b_mul, b_sqr, b_sel, b_rise, b_wrap;
        int cyc;
        bit armed, injected;
        c_val = c;
        d_reg = d;
        lat_min = lmin;
        lat_max = lmax;
        b_wr_r = n_wr_r; b_wr_c = n_wr_c; b_mul = n_mul; b_sqr = n_sqr;
        b_sel = sel_err; b_rise = ready_rises; b_wrap = wraps;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        check({tag, " init_o@t+1"}, 32'(init_o), 32'd1);
        check({tag, " busy@t+1"},   32'(busy),   32'd1);
        check({tag, " ready@t+1"},  32'(ready),  32'd0);
        armed = 1'b0;
        injected = 1'b0;
        while (!ready && cyc < BUDGET) begin
            if (inject && !injected && mm_start && mm_sel_b) armed = 1'b1;
            tick();
            cyc++;
            start = 1'b0;
            if (armed && !injected) begin
                start = 1'b1;
                injected = 1'b1;
            end
        end
        start = 1'b0;
        check({tag, " ready rose in budget"}, 32'(ready), 32'd1);
        check({tag, " wr_out with ready"}, 32'(wr_out), 32'd1);
        if (exp_cyc != 0) check({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
        tick();
        check({tag, " a0"}, 32'(a0), 32'(exp_a0));
        repeat (3) tick();
        check({tag, " ready held"}, 32'(ready), 32'd1);
        check({tag, " busy low"}, 32'(busy), 32'd0);
        check({tag, " wr_r count"}, 32'(n_wr_r - b_wr_r), 32'(exp_mul));
        check({tag, " wr_c count"}, 32'(n_wr_c - b_wr_c), 32'(W - 1));
        check({tag, " mul count"}, 32'(n_mul - b_mul), 32'(exp_mul));
        check({tag, " sqr count"}, 32'(n_sqr - b_sqr), 32'(W - 1));
        check({tag, " sel stable"}, 32'(sel_err - b_sel), 32'd0);
        check({tag, " ready rises"}, 32'(ready_rises - b_rise), 32'd1);
        check({tag, " idx wraps"}, 32'(wraps - b_wrap), 32'd0);
    endtask

    typedef struct {
        logic [7:0] c;
        logic [7:0] d;
        int         lat;
        logic [7:0] a0;
        int         cyc;
        int         nmul;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int b_wr_r, b_done;
        logic [7:0] rc, rd;
        int rl;

        // cycles = 25 + popcount(d)*(L+1) + 7*L for W=8
        vecs[0] = '{c: 8'h02, d: 8'h0D, lat: 3, a0: 8'hA0, cyc: 58, nmul: 3};
        vecs[1] = '{c: 8'h02, d: 8'h00, lat: 3, a0: 8'h01, cyc: 46, nmul: 0};
        vecs[2] = '{c: 8'h03, d: 8'hFF, lat: 3, a0: 8'hF3, cyc: 78, nmul: 8};
        vecs[3] = '{c: 8'h05, d: 8'h01, lat: 1, a0: 8'h05, cyc: 34, nmul: 1};
        vecs[4] = '{c: 8'h02, d: 8'h80, lat: 2, a0: 8'hF3, cyc: 42, nmul: 1};
        vecs[5] = '{c: 8'h10, d: 8'h02, lat: 4, a0: 8'h05, cyc: 58, nmul: 1};

        repeat (3) tick();
        check("rst ready",    32'(ready),    32'd0);
        check("rst busy",     32'(busy),     32'd0);
        check("rst exp_idx",  32'(exp_idx),  32'd0);
        check("rst init_o",   32'(init_o),   32'd0);
        check("rst mm_start", 32'(mm_start), 32'd0);
        check("rst wr_out",   32'(wr_out),   32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check("post-rst ready", 32'(ready), 32'd0);
        check("post-rst busy",  32'(busy),  32'd0);

        for (int i = 0; i < 6; i++) begin
            run($sformatf("vec%0d", i), vecs[i].c, vecs[i].d, vecs[i].lat, vecs[i].lat,
                vecs[i].a0, vecs[i].cyc, vecs[i].nmul, 1'b0);
        end

        // stray start while a squaring is outstanding
        run("inject", 8'h02, 8'h0D, 3, 3, 8'hA0, 58, 3, 1'b1);

        // reset while waiting on a multiply with mm_done still to come
        c_val = 8'h02;
        d_reg = 8'h0D;
        lat_min = 6;
        lat_max = 6;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20 && !(mm_start && !mm_sel_b); k++) tick();
        check("rstmid saw MUL", 32'(mm_start && !mm_sel_b), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        b_wr_r = n_wr_r;
        b_done = n_done;
        check("rstmid ready",    32'(ready),    32'd0);
        check("rstmid busy",     32'(busy),     32'd0);
        check("rstmid exp_idx",  32'(exp_idx),  32'd0);
        check("rstmid strobes",  32'({init_o, mm_start, mm_sel_b, wr_out, wr_r, wr_c}), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (8) tick();
        check("rstmid late done seen", 32'(n_done - b_done), 32'd1);
        check("rstmid no wr_r", 32'(n_wr_r - b_wr_r), 32'd0);
        check("rstmid ready after", 32'(ready), 32'd0);
        check("rstmid busy after",  32'(busy),  32'd0);
        run("after-rst", 8'h02, 8'h0D, 3, 3, 8'hA0, 58, 3, 1'b0);

        // random latency per operation against the reference model
        for (int i = 0; i < 6; i++) begin
            rc = 8'($urandom_range(250, 1));
            rd = 8'($urandom_range(255, 0));
            rl = int'($urandom_range(20, 1));
            run($sformatf("rnd%0d", i), rc, rd, 1, rl, modexp_ref(rc, rd), 0,
                $countones(rd), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
